// File: rtl/lcg_stream_checker.sv
// Receive-side monitor for an LCG word stream: locks onto the sequence
// x[n+1] = x[n]*MULT + INC from any seed and counts matching/mismatching beats.
module lcg_stream_checker #(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned MULT         = 1103515245,
  parameter int unsigned INC          = 12345,
  parameter int unsigned LOCK_COUNT   = 4,
  parameter int unsigned CNT_WIDTH    = 16,
  localparam int unsigned STREAK_WIDTH = $clog2(LOCK_COUNT + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clear,
  input  logic                    in_valid,
  input  logic [DATA_WIDTH-1:0]   in_data,
  output logic                    locked,
  output logic                    mismatch,
  output logic [DATA_WIDTH-1:0]   expected,
  output logic [CNT_WIDTH-1:0]    match_count,
  output logic [CNT_WIDTH-1:0]    err_count,
  output logic [1:0]              state_dbg,
  output logic [STREAK_WIDTH-1:0] streak_dbg
);

  // Handshake: in_valid alone qualifies a beat; there is no ready, every
  // valid beat is consumed on the rising edge where in_valid is high.

  localparam logic [DATA_WIDTH-1:0]   MULT_W = DATA_WIDTH'(MULT);
  localparam logic [DATA_WIDTH-1:0]   INC_W  = DATA_WIDTH'(INC);
  localparam logic [STREAK_WIDTH-1:0] LOCK_W = STREAK_WIDTH'(LOCK_COUNT);

  typedef enum logic [1:0] {
    ST_UNLOCKED = 2'd0,
    ST_ACQUIRE  = 2'd1,
    ST_LOCKED   = 2'd2
  } state_t;

  state_t                  state_q, state_n;
  logic [DATA_WIDTH-1:0]   prev_q, prev_n;
  logic [STREAK_WIDTH-1:0] streak_q, streak_n;
  logic                    bad_q, bad_n;
  logic [DATA_WIDTH-1:0]   recover_q, recover_n;
  logic                    locked_q, locked_n;
  logic                    mismatch_q, mismatch_n;
  logic [DATA_WIDTH-1:0]   expected_q, expected_n;
  logic [CNT_WIDTH-1:0]    match_q, match_n;
  logic [CNT_WIDTH-1:0]    err_q, err_n;

  logic [DATA_WIDTH-1:0]   pred;
  logic [DATA_WIDTH-1:0]   pred_in;
  logic [DATA_WIDTH-1:0]   pred_skip;
  logic [STREAK_WIDTH-1:0] streak_inc;
  logic                    hit;

  assign pred       = prev_q * MULT_W + INC_W;
  assign pred_in    = in_data * MULT_W + INC_W;
  // Word that follows the one we expected; a lone corrupted beat is
  // recognised when the stream resumes with this value.
  assign pred_skip  = expected_q * MULT_W + INC_W;
  assign streak_inc = streak_q + 1'b1;
  assign hit        = (in_data == pred);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_UNLOCKED;
      prev_q     <= '0;
      streak_q   <= '0;
      bad_q      <= 1'b0;
      recover_q  <= '0;
      locked_q   <= 1'b0;
      mismatch_q <= 1'b0;
      expected_q <= '0;
      match_q    <= '0;
      err_q      <= '0;
    end else begin
      state_q    <= state_n;
      prev_q     <= prev_n;
      streak_q   <= streak_n;
      bad_q      <= bad_n;
      recover_q  <= recover_n;
      locked_q   <= locked_n;
      mismatch_q <= mismatch_n;
      expected_q <= expected_n;
      match_q    <= match_n;
      err_q      <= err_n;
    end
  end

  always_comb begin
    state_n    = state_q;
    prev_n     = prev_q;
    streak_n   = streak_q;
    bad_n      = bad_q;
    recover_n  = recover_q;
    mismatch_n = 1'b0;
    expected_n = expected_q;
    match_n    = match_q;
    err_n      = err_q;

    if (clear) begin
      state_n    = ST_UNLOCKED;
      prev_n     = '0;
      streak_n   = '0;
      bad_n      = 1'b0;
      recover_n  = '0;
      expected_n = '0;
      match_n    = '0;
      err_n      = '0;
    end else if (in_valid) begin
      prev_n     = in_data;
      expected_n = pred_in;
      case (state_q)
        ST_UNLOCKED: begin
          streak_n = '0;
          state_n  = ST_ACQUIRE;
        end
        ST_ACQUIRE: begin
          if (hit) begin
            if (streak_inc == LOCK_W) begin
              state_n  = ST_LOCKED;
              streak_n = '0;
              bad_n    = 1'b0;
            end else begin
              streak_n = streak_inc;
            end
          end else begin
            streak_n = '0;
          end
        end
        ST_LOCKED: begin
          if (hit) begin
            bad_n = 1'b0;
            if (match_q != '1) match_n = match_q + 1'b1;
          end else begin
            mismatch_n = 1'b1;
            if (err_q != '1) err_n = err_q + 1'b1;
            if (!bad_q) begin
              bad_n     = 1'b1;
              recover_n = pred_skip;
            end else if (in_data == recover_q) begin
              // Good word mispredicted from a single bad one: keep lock.
              bad_n = 1'b0;
            end else begin
              state_n  = ST_ACQUIRE;
              streak_n = '0;
              bad_n    = 1'b0;
            end
          end
        end
        default: state_n = ST_UNLOCKED;
      endcase
    end
  end

  assign locked_n    = (state_n == ST_LOCKED);
  assign locked      = locked_q;
  assign mismatch    = mismatch_q;
  assign expected    = expected_q;
  assign match_count = match_q;
  assign err_count   = err_q;
  assign state_dbg   = state_q;
  assign streak_dbg  = streak_q;

endmodule

// File: tb/tb_lcg_stream_checker.sv
// Directed bench for lcg_stream_checker: 8-bit LCG (x*5+1) scenarios plus a
// default-parameter instance for the 32-bit seed check.
module tb_lcg_stream_checker;

  localparam logic [1:0] S_UNLOCKED = 2'd0;
  localparam logic [1:0] S_ACQUIRE  = 2'd1;

  logic       clk;
  logic       rst;
  logic       clear;
  logic       in_valid;
  logic [7:0] in_data;
  logic       locked;
  logic       mismatch;
  logic [7:0] expected;
  logic [7:0] match_count;
  logic [7:0] err_count;
  logic [1:0] state_dbg;
  logic [2:0] streak_dbg;

  logic        clear32;
  logic        in_valid32;
  logic [31:0] in_data32;
  logic        locked32;
  logic        mismatch32;
  logic [31:0] expected32;
  logic [15:0] match_count32;
  logic [15:0] err_count32;
  logic [1:0]  state_dbg32;
  logic [2:0]  streak_dbg32;

  int checks;
  int failures;

  lcg_stream_checker #(
    .DATA_WIDTH(8), .MULT(5), .INC(1), .LOCK_COUNT(4), .CNT_WIDTH(8)
  ) u_dut (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_data(in_data),
    .locked(locked), .mismatch(mismatch), .expected(expected),
    .match_count(match_count), .err_count(err_count),
    .state_dbg(state_dbg), .streak_dbg(streak_dbg)
  );

  lcg_stream_checker u_dut32 (
    .clk(clk), .rst(rst), .clear(clear32), .in_valid(in_valid32), .in_data(in_data32),
    .locked(locked32), .mismatch(mismatch32), .expected(expected32),
    .match_count(match_count32), .err_count(err_count32),
    .state_dbg(state_dbg32), .streak_dbg(streak_dbg32)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_reset();
    rst = 1'b1; clear = 1'b0; in_valid = 1'b0; in_data = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Drivers: inputs change on the falling edge, outputs sampled 1 after rise.
  task automatic beat(input logic [7:0] d);
    @(negedge clk);
    in_valid = 1'b1; in_data = d;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic beat32(input logic [31:0] d);
    @(negedge clk);
    in_valid32 = 1'b1; in_data32 = d;
    @(posedge clk); #1;
    in_valid32 = 1'b0;
  endtask

  task automatic lock_seq();
    beat(8'd0); beat(8'd1); beat(8'd6); beat(8'd31); beat(8'd156);
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (locked !== 1'b0) begin failures++; $display("FAIL reset_locked got=%0d exp=0", locked); end
    checks++; if (mismatch !== 1'b0) begin failures++; $display("FAIL reset_mismatch got=%0d exp=0", mismatch); end
    checks++; if (expected !== 8'd0) begin failures++; $display("FAIL reset_expected got=%0d exp=0", expected); end
    checks++; if (match_count !== 8'd0 || err_count !== 8'd0) begin failures++; $display("FAIL reset_counts got=%0d/%0d exp=0/0", match_count, err_count); end
    checks++; if (state_dbg !== S_UNLOCKED) begin failures++; $display("FAIL reset_state got=%0d exp=0", state_dbg); end
  endtask

  task automatic test_clean_lock();
    do_reset();
    beat(8'd0); beat(8'd1); beat(8'd6); beat(8'd31);
    checks++; if (locked !== 1'b0) begin failures++; $display("FAIL lock_early got=%0d exp=0", locked); end
    checks++; if (streak_dbg !== 3'd3) begin failures++; $display("FAIL lock_streak got=%0d exp=3", streak_dbg); end
    beat(8'd156);
    checks++; if (locked !== 1'b1) begin failures++; $display("FAIL lock_locked got=%0d exp=1", locked); end
    checks++; if (expected !== 8'd13) begin failures++; $display("FAIL lock_expected got=%0d exp=13", expected); end
    checks++; if (match_count !== 8'd0 || err_count !== 8'd0) begin failures++; $display("FAIL lock_counts got=%0d/%0d exp=0/0", match_count, err_count); end
  endtask

  task automatic test_tracking();
    logic seen_mm;
    seen_mm = 1'b0;
    beat(8'd13); seen_mm |= mismatch;
    beat(8'd66); seen_mm |= mismatch;
    beat(8'd75); seen_mm |= mismatch;
    checks++; if (seen_mm !== 1'b0) begin failures++; $display("FAIL track_mismatch got=%0d exp=0", seen_mm); end
    checks++; if (match_count !== 8'd3) begin failures++; $display("FAIL track_match got=%0d exp=3", match_count); end
    checks++; if (expected !== 8'd120) begin failures++; $display("FAIL track_expected got=%0d exp=120", expected); end
    checks++; if (locked !== 1'b1) begin failures++; $display("FAIL track_locked got=%0d exp=1", locked); end
  endtask

  task automatic test_single_corruption();
    do_reset();
    lock_seq(); beat(8'd13); beat(8'd66);
    beat(8'd99);
    checks++; if (mismatch !== 1'b1) begin failures++; $display("FAIL sc_mm1 got=%0d exp=1", mismatch); end
    checks++; if (err_count !== 8'd1) begin failures++; $display("FAIL sc_err1 got=%0d exp=1", err_count); end
    checks++; if (expected !== 8'd240) begin failures++; $display("FAIL sc_expected got=%0d exp=240", expected); end
    beat(8'd120);
    checks++; if (mismatch !== 1'b1) begin failures++; $display("FAIL sc_mm2 got=%0d exp=1", mismatch); end
    checks++; if (locked !== 1'b1) begin failures++; $display("FAIL sc_locked2 got=%0d exp=1", locked); end
    checks++; if (err_count !== 8'd2) begin failures++; $display("FAIL sc_err2 got=%0d exp=2", err_count); end
    beat(8'd89);
    checks++; if (mismatch !== 1'b0) begin failures++; $display("FAIL sc_mm3 got=%0d exp=0", mismatch); end
    checks++; if (locked !== 1'b1) begin failures++; $display("FAIL sc_locked3 got=%0d exp=1", locked); end
    checks++; if (match_count !== 8'd3) begin failures++; $display("FAIL sc_match got=%0d exp=3", match_count); end
    checks++; if (err_count !== 8'd2) begin failures++; $display("FAIL sc_err3 got=%0d exp=2", err_count); end
  endtask

  task automatic test_double_corruption();
    do_reset();
    lock_seq(); beat(8'd13); beat(8'd66);
    beat(8'd200);
    checks++; if (locked !== 1'b1 || err_count !== 8'd1) begin failures++; $display("FAIL dc_first got=%0d/%0d exp=1/1", locked, err_count); end
    beat(8'd17);
    checks++; if (locked !== 1'b0) begin failures++; $display("FAIL dc_unlock got=%0d exp=0", locked); end
    checks++; if (err_count !== 8'd2) begin failures++; $display("FAIL dc_err got=%0d exp=2", err_count); end
    checks++; if (mismatch !== 1'b1) begin failures++; $display("FAIL dc_mm got=%0d exp=1", mismatch); end
    checks++; if (state_dbg !== S_ACQUIRE) begin failures++; $display("FAIL dc_state got=%0d exp=1", state_dbg); end
    beat(8'd86); beat(8'd175); beat(8'd108);
    checks++; if (locked !== 1'b0) begin failures++; $display("FAIL dc_relock_early got=%0d exp=0", locked); end
    beat(8'd29);
    checks++; if (locked !== 1'b1) begin failures++; $display("FAIL dc_relock got=%0d exp=1", locked); end
    checks++; if (expected !== 8'd146) begin failures++; $display("FAIL dc_expected got=%0d exp=146", expected); end
    checks++; if (match_count !== 8'd2 || err_count !== 8'd2) begin failures++; $display("FAIL dc_counts got=%0d/%0d exp=2/2", match_count, err_count); end
  endtask

  task automatic test_gaps_clear();
    do_reset();
    beat(8'd0); idle(); beat(8'd1); idle(); idle(); beat(8'd6); beat(8'd31); idle();
    checks++; if (locked !== 1'b0 || streak_dbg !== 3'd3) begin failures++; $display("FAIL gap_pre got=%0d/%0d exp=0/3", locked, streak_dbg); end
    beat(8'd156);
    checks++; if (locked !== 1'b1 || expected !== 8'd13) begin failures++; $display("FAIL gap_lock got=%0d/%0d exp=1/13", locked, expected); end
    checks++; if (match_count !== 8'd0 || err_count !== 8'd0) begin failures++; $display("FAIL gap_counts got=%0d/%0d exp=0/0", match_count, err_count); end
    beat(8'd13); beat(8'd77);
    checks++; if (mismatch !== 1'b1 || err_count !== 8'd1) begin failures++; $display("FAIL gap_err got=%0d/%0d exp=1/1", mismatch, err_count); end
    idle();
    checks++; if (mismatch !== 1'b0 || err_count !== 8'd1) begin failures++; $display("FAIL gap_idle got=%0d/%0d exp=0/1", mismatch, err_count); end
    @(negedge clk);
    clear = 1'b1; in_valid = 1'b1; in_data = 8'd66;
    @(posedge clk); #1;
    clear = 1'b0; in_valid = 1'b0;
    checks++; if (match_count !== 8'd0 || err_count !== 8'd0) begin failures++; $display("FAIL clr_counts got=%0d/%0d exp=0/0", match_count, err_count); end
    checks++; if (locked !== 1'b0 || mismatch !== 1'b0) begin failures++; $display("FAIL clr_flags got=%0d/%0d exp=0/0", locked, mismatch); end
    checks++; if (state_dbg !== S_UNLOCKED || expected !== 8'd0) begin failures++; $display("FAIL clr_state got=%0d/%0d exp=0/0", state_dbg, expected); end
    beat(8'd5); beat(8'd26);
    checks++; if (state_dbg !== S_ACQUIRE || streak_dbg !== 3'd1) begin failures++; $display("FAIL clr_reseed got=%0d/%0d exp=1/1", state_dbg, streak_dbg); end
  endtask

  task automatic test_async_reset();
    do_reset();
    lock_seq(); beat(8'd13); beat(8'd200);
    rst = 1'b1;
    #1;
    checks++; if (locked !== 1'b0 || mismatch !== 1'b0) begin failures++; $display("FAIL ar_flags got=%0d/%0d exp=0/0", locked, mismatch); end
    checks++; if (match_count !== 8'd0 || err_count !== 8'd0) begin failures++; $display("FAIL ar_counts got=%0d/%0d exp=0/0", match_count, err_count); end
    checks++; if (expected !== 8'd0 || state_dbg !== S_UNLOCKED) begin failures++; $display("FAIL ar_state got=%0d/%0d exp=0/0", expected, state_dbg); end
    @(negedge clk);
    rst = 1'b0;
    beat(8'd0);
    checks++; if (state_dbg !== S_ACQUIRE || err_count !== 8'd0 || mismatch !== 1'b0) begin failures++; $display("FAIL ar_seed got=%0d/%0d/%0d exp=1/0/0", state_dbg, err_count, mismatch); end
    checks++; if (expected !== 8'd1) begin failures++; $display("FAIL ar_expected got=%0d exp=1", expected); end
  endtask

  task automatic test_default_width();
    beat32(32'd123456);
    checks++; if (state_dbg32 !== S_ACQUIRE) begin failures++; $display("FAIL dw_state got=%0d exp=1", state_dbg32); end
    checks++; if (expected32 !== 32'd3510437241) begin failures++; $display("FAIL dw_expected got=%0d exp=3510437241", expected32); end
    beat32(32'd3510437241);
    checks++; if (streak_dbg32 !== 3'd1) begin failures++; $display("FAIL dw_streak got=%0d exp=1", streak_dbg32); end
    checks++; if (err_count32 !== 16'd0 || mismatch32 !== 1'b0 || locked32 !== 1'b0) begin failures++; $display("FAIL dw_flags got=%0d/%0d/%0d exp=0/0/0", err_count32, mismatch32, locked32); end
  endtask

  task automatic test_saturation();
    logic [7:0] x;
    do_reset();
    lock_seq();
    x = 8'd13;
    for (int i = 0; i < 260; i++) begin
      beat(x);
      x = x * 8'd5 + 8'd1;
    end
    checks++; if (match_count !== 8'd255) begin failures++; $display("FAIL sat_match got=%0d exp=255", match_count); end
    checks++; if (err_count !== 8'd0 || locked !== 1'b1) begin failures++; $display("FAIL sat_flags got=%0d/%0d exp=0/1", err_count, locked); end
  endtask

  initial begin
    checks = 0; failures = 0;
    rst = 1'b1; clear = 1'b0; in_valid = 1'b0; in_data = '0;
    clear32 = 1'b0; in_valid32 = 1'b0; in_data32 = '0;
    test_reset();
    test_clean_lock();
    test_tracking();
    test_single_corruption();
    test_double_corruption();
    test_gaps_clear();
    test_async_reset();
    test_default_width();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
